// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encoding and sizing constants.
package cpu_defs_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
// start is sampled only while the divider is idle; done is a one-cycle result strobe.
interface div_unit_if #(
  parameter int WIDTH = cpu_defs_pkg::DIV_WIDTH
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, sign, dividend, divisor, cancel,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, sign, dividend, divisor, cancel,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on magnitudes:
// shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_mag};

  // A negative trial implies shifted < div_mag, so its top bit is zero and can be dropped.
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring DIV/DIVU unit writing LO (quotient) and HI (remainder).
// Optional DIV_ZERO_FAST_EN: a zero divisor completes in one cycle with fixed results.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus,
  output div_state_t state_dbg
);

  localparam int CNT_W = DIV_CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             negq;
  logic             negr;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             fast_zero;

  assign dvd_mag = (bus.sign && bus.dividend[WIDTH-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag = (bus.sign && bus.divisor[WIDTH-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (bus.divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .div_mag  (div_mag),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      div_mag     <= '0;
      negq        <= 1'b0;
      negr        <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            count <= '0;
            if (bus.start) begin
              if (fast_zero) begin
                state       <= DONE;
                done_r      <= 1'b1;
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
              end else begin
                state   <= CALC;
                rem     <= '0;
                quo     <= dvd_mag;
                div_mag <= dvs_mag;
                negq    <= bus.sign & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                negr    <= bus.sign & bus.dividend[WIDTH-1];
              end
            end
          end
          CALC: begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count + 1'b1;
            if (count == LAST) state <= SIGN;
          end
          SIGN: begin
            quotient_r  <= negq ? (~quo + 1'b1) : quo;
            remainder_r <= negr ? (~rem + 1'b1) : rem;
            done_r      <= 1'b1;
            state       <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A flush arriving in the DONE cycle must suppress the result strobe.
  assign bus.done      = done_r & ~bus.cancel;
  assign bus.busy      = bus.start | (state == CALC) | (state == SIGN);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, random operands, and directed
// sequences for cancel, ignored start, reset mid-operation and divide by zero.
module tb_div_unit;
  import cpu_defs_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + 8;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  div_state_t state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int passed = 0;
  int total = 0;
  int start_cyc = 0;
  int done_count = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (resetn && bus.done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: actual=done at cycle %0d required=no done", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", bus.quotient, e[2*W-1:W]);
          chk("remainder", bus.remainder, e[W-1:0]);
          chk("latency", W'(cyc - start_cyc), W'(e[EW-1:2*W]));
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // rel 0 is the start cycle; busy must be high for rel < lat and done at rel == lat.
  task automatic run_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat, input int pulse_rel);
    int  bad;
    logic seen;
    logic nxt;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = sg; bus.dividend = a; bus.divisor = b;
    start_cyc = cyc;
    exp_q.push_back({8'(lat), eq, er});
    bad = -1;
    seen = 1'b0;
    for (int rel = 0; rel < 45; rel++) begin
      @(negedge clk);
      if (bad < 0 && bus.busy !== (rel < lat)) bad = rel;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      nxt = (rel + 1 == pulse_rel);
      if (nxt != bus.start) begin
        @(posedge clk); #1;
        bus.start = nxt;
        if (nxt) begin
          bus.sign = 1'b0; bus.dividend = 32'h55; bus.divisor = 32'h1;
        end
      end
    end
    chk("busy_window_first_bad_rel", W'(bad), '1);
    if (!seen) begin
      total++;
      $display("FAIL done_timeout: actual=no done required=done at rel %0d", lat);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    #1;
    last_q = eq;
    last_r = er;
  endtask

  // ---------------- test ----------------
  initial begin
    int d0;
    logic sg;
    logic [W-1:0] a, b, q, r;
    logic signed [W-1:0] sa, sb;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[4] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[6] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
    vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[9] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF};

    bus.start = 1'b0; bus.sign = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.cancel = 1'b0;

    // Reset state: outputs cleared, busy follows start.
    #2;
    bus.start = 1'b1;
    #1;
    chk("reset_busy_follows_start", W'(bus.busy), 32'd1);
    chk("reset_done", W'(bus.done), 32'd0);
    chk("reset_quotient", bus.quotient, 32'd0);
    chk("reset_remainder", bus.remainder, 32'd0);
    chk("reset_state", W'(state_dbg), W'(IDLE));
    bus.start = 1'b0;
    #1;
    chk("reset_busy_idle", W'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    fork
      monitor();
    join_none

    for (int i = 0; i < 10; i++)
      run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 34, -1);

    for (int i = 0; i < 6; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = (i < 3) ? $urandom : 32'($urandom_range(1, 1000));
      if (b == '0) b = 32'd1;
      if (sg) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'd1;
        sa = a; sb = b;
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
      run_div(sg, a, b, q, r, 34, -1);
    end

    // Results hold through IDLE.
    repeat (5) @(negedge clk);
    chk("hold_quotient", bus.quotient, last_q);
    chk("hold_remainder", bus.remainder, last_r);
    chk("hold_busy", W'(bus.busy), 32'd0);

    // Cancel at rel 10: IDLE at rel 11, no done, results untouched.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    d0 = done_count;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel_state", W'(state_dbg), W'(IDLE));
    chk("cancel_busy", W'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_no_done", W'(done_count - d0), 32'd0);
    chk("cancel_quotient_kept", bus.quotient, last_q);
    chk("cancel_remainder_kept", bus.remainder, last_r);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, -1);

    // start re-pulsed during CALC is ignored: one done, original result.
    d0 = done_count;
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 5);
    repeat (40) @(negedge clk);
    chk("repulse_single_done", W'(done_count - d0), 32'd1);

    // start and cancel together in IDLE: nothing starts.
    d0 = done_count;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cancel = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_state", W'(state_dbg), W'(IDLE));
    repeat (40) @(negedge clk);
    chk("start_cancel_no_done", W'(done_count - d0), 32'd0);

    // Divide by zero.
    run_div(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, ZLAT, -1);

    // Reset mid-CALC clears outputs and suppresses done.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("midcalc_state", W'(state_dbg), W'(CALC));
    d0 = done_count;
    resetn = 1'b0;
    #1;
    chk("midreset_state", W'(state_dbg), W'(IDLE));
    chk("midreset_quotient", bus.quotient, 32'd0);
    chk("midreset_remainder", bus.remainder, 32'd0);
    chk("midreset_done", W'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_no_done", W'(done_count - d0), 32'd0);

    chk("queue_empty", W'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
